// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV64 instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_TARGET
  } pc_sel_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

  // A bubble keeps the stale PC fields; only valid/instr carry meaning.
  function automatic ifid_t ifid_bubble(input ifid_t cur);
    ifid_t b;
    b       = cur;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, hazard/redirect and IF/ID signals.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic [XLEN-1:0]    imem_adr;
  logic [INSTR_W-1:0] imem_instr;
  logic               stall;
  logic               redirect;
  logic [XLEN-1:0]    redirect_target;
  logic               flush;
  logic [XLEN-1:0]    ifid_pc;
  logic [XLEN-1:0]    ifid_pc_plus4;
  logic [INSTR_W-1:0] ifid_instr;
  logic               ifid_valid;
  logic               fetch_fault;
  logic [31:0]        fetch_count;

  modport master (
    output imem_adr,
    input  imem_instr,
    input  stall,
    input  redirect,
    input  redirect_target,
    input  flush,
    output ifid_pc,
    output ifid_pc_plus4,
    output ifid_instr,
    output ifid_valid,
    output fetch_fault,
    output fetch_count
  );

  modport slave (
    input  imem_adr,
    output imem_instr,
    output stall,
    output redirect,
    output redirect_target,
    output flush,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  ifid_instr,
    input  ifid_valid,
    input  fetch_fault,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// PC register with next-PC mux; flags misaligned redirect targets and
// fetch addresses past the end of instruction memory.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] IMEM_SIZE = 64'd64
) (
  input  logic            clk,
  input  logic            reset,
  input  pc_sel_t         pc_sel,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            bad_target,
  output logic            out_of_range
);

  localparam logic [XLEN-1:0] LAST_PC = IMEM_SIZE - 64'd4;

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_pc_gen: RESET_PC must be 4-byte aligned");
  end
  if (IMEM_SIZE < 64'd4) begin : g_bad_imem_size
    $error("fetch_pc_gen: IMEM_SIZE must hold at least one instruction");
  end

  logic [XLEN-1:0] pc_next;

  assign pc_plus4     = pc + 64'd4;
  assign bad_target   = redirect && (redirect_target[1:0] != 2'b00);
  assign out_of_range = pc > LAST_PC;

  always_comb begin
    pc_next = pc;
    unique case (pc_sel)
      PC_SEQ:    pc_next = pc_plus4;
      PC_TARGET: pc_next = redirect_target;
      default:   pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register, and
// faults after running past the program without a redirect to recover.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 64'h0,
  parameter logic [XLEN-1:0] IMEM_SIZE    = 64'd64,
  parameter int unsigned     DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("fetch_stage: DRAIN_CYCLES must be at least 1");
  end

  fetch_state_t    state, state_next;
  pc_sel_t         pc_sel;
  ifid_t           ifid, ifid_next;
  logic            fault, fault_next;
  logic [DW-1:0]   drain_cnt, drain_next, drain_inc;
  logic [31:0]     count;
  logic            load;
  logic [XLEN-1:0] pc, pc_plus4;
  logic            bad_target, out_of_range;

  fetch_pc_gen #(
    .RESET_PC  (RESET_PC),
    .IMEM_SIZE (IMEM_SIZE)
  ) u_pc_gen (
    .clk             (clk),
    .reset           (reset),
    .pc_sel          (pc_sel),
    .redirect        (bus.redirect),
    .redirect_target (bus.redirect_target),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .bad_target      (bad_target),
    .out_of_range    (out_of_range)
  );

  assign drain_inc = drain_cnt + DW'(1);

  always_comb begin
    state_next = state;
    pc_sel     = PC_HOLD;
    ifid_next  = ifid;
    fault_next = fault;
    drain_next = drain_cnt;
    load       = 1'b0;
    unique case (state)
      RUN: begin
        if (bad_target) begin
          state_next = HALT;
          fault_next = 1'b1;
          ifid_next  = ifid_bubble(ifid);
        end else if (bus.redirect) begin
          pc_sel    = PC_TARGET;
          ifid_next = ifid_bubble(ifid);
        end else if (out_of_range) begin
          // Word at an illegal address is never captured; PC parks here.
          state_next = DRAIN;
          drain_next = DW'(1);
          if (bus.flush || !bus.stall) ifid_next = ifid_bubble(ifid);
        end else begin
          pc_sel = bus.stall ? PC_HOLD : PC_SEQ;
          if (bus.flush) begin
            ifid_next = ifid_bubble(ifid);
          end else if (!bus.stall) begin
            load      = 1'b1;
            ifid_next = '{pc: pc, pc_plus4: pc_plus4, instr: bus.imem_instr, valid: 1'b1};
          end
        end
      end
      DRAIN: begin
        if (bad_target) begin
          state_next = HALT;
          fault_next = 1'b1;
          ifid_next  = ifid_bubble(ifid);
        end else if (bus.redirect) begin
          state_next = RUN;
          pc_sel     = PC_TARGET;
          drain_next = '0;
          ifid_next  = ifid_bubble(ifid);
        end else begin
          if (bus.flush || !bus.stall) ifid_next = ifid_bubble(ifid);
          if (32'(drain_inc) >= DRAIN_CYCLES) begin
            state_next = HALT;
            fault_next = 1'b1;
          end else begin
            drain_next = drain_inc;
          end
        end
      end
      HALT: begin
        fault_next = 1'b1;
        ifid_next  = ifid_bubble(ifid);
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      ifid      <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
      fault     <= 1'b0;
      drain_cnt <= '0;
      count     <= '0;
    end else begin
      state     <= state_next;
      ifid      <= ifid_next;
      fault     <= fault_next;
      drain_cnt <= drain_next;
      if (load && (count != '1)) count <= count + 32'd1;
    end
  end

  assign bus.imem_adr      = pc;
  assign bus.ifid_pc       = ifid.pc;
  assign bus.ifid_pc_plus4 = ifid.pc_plus4;
  assign bus.ifid_instr    = ifid.instr;
  assign bus.ifid_valid    = ifid.valid;
  assign bus.fetch_fault   = fault;
  assign bus.fetch_count   = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mem [16];

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC     (64'h0),
    .IMEM_SIZE    (64'd64),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = (bus.imem_adr < 64'd64) ? mem[bus.imem_adr[5:2]] : 32'hDEADBEEF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 32'h003100B3;
    mem[1] = 32'h0062F233;
    for (int unsigned i = 2; i < 16; i++) mem[i] = 32'h00000013 | (i << 20);

    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    bus.flush = 1'b0;
    tick();
    tick();
    check("rst_adr", bus.imem_adr, 64'h0);
    check("rst_valid", bus.ifid_valid, 0);
    check("rst_instr", bus.ifid_instr, 64'h13);
    check("rst_pc", bus.ifid_pc, 0);
    check("rst_pc4", bus.ifid_pc_plus4, 0);
    check("rst_fault", bus.fetch_fault, 0);
    check("rst_count", bus.fetch_count, 0);
    reset = 1'b0;

    // Sequential fetch of the first word.
    tick();
    check("t1_adr", bus.imem_adr, 64'h4);
    check("t1_instr0", bus.ifid_instr, 64'h003100B3);
    check("t1_pc0", bus.ifid_pc, 64'h0);
    check("t1_pc4_0", bus.ifid_pc_plus4, 64'h4);
    check("t1_valid0", bus.ifid_valid, 1);
    check("t1_count1", bus.fetch_count, 1);

    // Two-cycle stall at pc=4.
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t2_adr_hold", bus.imem_adr, 64'h4);
      check("t2_instr_hold", bus.ifid_instr, 64'h003100B3);
      check("t2_pc_hold", bus.ifid_pc, 64'h0);
      check("t2_count_hold", bus.fetch_count, 1);
    end
    bus.stall = 1'b0;
    tick();
    check("t2_adr8", bus.imem_adr, 64'h8);
    check("t2_instr1", bus.ifid_instr, 64'h0062F233);
    check("t2_pc1", bus.ifid_pc, 64'h4);
    check("t2_pc4_1", bus.ifid_pc_plus4, 64'h8);
    check("t2_count2", bus.fetch_count, 2);

    // Redirect with simultaneous stall at pc=8.
    bus.redirect = 1'b1;
    bus.redirect_target = 64'h0;
    bus.stall = 1'b1;
    tick();
    check("t3_adr0", bus.imem_adr, 64'h0);
    check("t3_valid", bus.ifid_valid, 0);
    check("t3_nop", bus.ifid_instr, 64'h13);
    check("t3_count", bus.fetch_count, 2);
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    tick();
    check("t3_adr4", bus.imem_adr, 64'h4);
    check("t3_instr0", bus.ifid_instr, 64'h003100B3);
    check("t3_pc0", bus.ifid_pc, 64'h0);
    check("t3_count3", bus.fetch_count, 3);

    // Run to the end of memory, then recover with a redirect in DRAIN.
    for (int k = 0; k < 15; k++) tick();
    check("t4_adr64", bus.imem_adr, 64'd64);
    check("t4_instr15", bus.ifid_instr, 64'h00F00013);
    check("t4_pc60", bus.ifid_pc, 64'd60);
    check("t4_count18", bus.fetch_count, 18);
    tick();
    check("t4_drain_adr", bus.imem_adr, 64'd64);
    check("t4_drain_valid", bus.ifid_valid, 0);
    check("t4_drain_count", bus.fetch_count, 18);
    bus.redirect = 1'b1;
    bus.redirect_target = 64'h0;
    tick();
    check("t4_redir_adr", bus.imem_adr, 64'h0);
    check("t4_redir_fault", bus.fetch_fault, 0);
    bus.redirect = 1'b0;
    tick();
    check("t4_run_adr", bus.imem_adr, 64'h4);
    check("t4_run_instr", bus.ifid_instr, 64'h003100B3);
    check("t4_run_valid", bus.ifid_valid, 1);
    check("t4_run_count", bus.fetch_count, 19);

    // Run off the end with no redirect: fault after DRAIN_CYCLES edges.
    for (int k = 0; k < 15; k++) tick();
    check("t5_adr64", bus.imem_adr, 64'd64);
    check("t5_count34", bus.fetch_count, 34);
    tick();
    check("t5_d1_fault", bus.fetch_fault, 0);
    tick();
    check("t5_d2_fault", bus.fetch_fault, 0);
    tick();
    check("t5_halt_fault", bus.fetch_fault, 1);
    check("t5_halt_adr", bus.imem_adr, 64'd64);
    check("t5_halt_valid", bus.ifid_valid, 0);
    bus.redirect = 1'b1;
    bus.redirect_target = 64'h0;
    tick();
    check("t5_ign_adr", bus.imem_adr, 64'd64);
    check("t5_ign_fault", bus.fetch_fault, 1);
    check("t5_ign_valid", bus.ifid_valid, 0);
    check("t5_ign_count", bus.fetch_count, 34);
    bus.redirect = 1'b0;
    reset = 1'b1;
    tick();
    check("t5_rst_adr", bus.imem_adr, 64'h0);
    check("t5_rst_fault", bus.fetch_fault, 0);
    check("t5_rst_count", bus.fetch_count, 0);
    reset = 1'b0;

    // Flush alone bubbles IF/ID but lets the PC advance.
    tick();
    check("fl_count1", bus.fetch_count, 1);
    bus.flush = 1'b1;
    tick();
    check("fl_adr8", bus.imem_adr, 64'h8);
    check("fl_valid", bus.ifid_valid, 0);
    check("fl_nop", bus.ifid_instr, 64'h13);
    check("fl_count", bus.fetch_count, 1);
    bus.flush = 1'b0;

    // Misaligned redirect target faults immediately.
    bus.redirect = 1'b1;
    bus.redirect_target = 64'h6;
    tick();
    check("t6_fault", bus.fetch_fault, 1);
    check("t6_valid", bus.ifid_valid, 0);
    check("t6_adr", bus.imem_adr, 64'h8);
    bus.redirect = 1'b0;
    tick();
    check("t6_fault_hold", bus.fetch_fault, 1);
    check("t6_valid_hold", bus.ifid_valid, 0);
    check("t6_count", bus.fetch_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
